// File: rtl/fft_spi_in_pkg.sv
// Shared constants for the FFT SPI link: frame geometry and the receiver state encodings.
package fft_spi_in_pkg;

    localparam int FFT_N   = 16;
    localparam int FFT_MSB = 8;

    localparam logic [1:0] IN_IDLE  = 2'd0;
    localparam logic [1:0] IN_SHIFT = 2'd1;
    localparam logic [1:0] IN_GAP   = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE  = IN_IDLE,
        ST_SHIFT = IN_SHIFT,
        ST_GAP   = IN_GAP
    } in_state_e;

endpackage

// File: rtl/fft_spi_in_if.sv
// SPI pins plus the parallel frame output of the FFT input receiver.
interface fft_spi_in_if
    import fft_spi_in_pkg::*;
#(
    parameter int N   = FFT_N,
    parameter int MSB = FFT_MSB
);

    logic                     sclk;
    logic                     mosi;
    logic                     cs;
    logic [2*N*MSB-1:0]       data_bus;
    logic                     frame_valid;
    logic                     frame_err;
    logic [$clog2(2*N)-1:0]   word_idx;

    modport slave (
        input  sclk,
        input  mosi,
        input  cs,
        output data_bus,
        output frame_valid,
        output frame_err,
        output word_idx
    );

    modport master (
        output sclk,
        output mosi,
        output cs,
        input  data_bus,
        input  frame_valid,
        input  frame_err,
        input  word_idx
    );

endinterface

// File: rtl/fft_spi_in_spi_sync_edge.sv
// Two-flop synchroniser for an asynchronous pin followed by a delayed copy for edge detection.
module spi_sync_edge #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic sync,
    output logic rise,
    output logic fall
);

    // [0] first sync stage, [1] synchronised level, [2] delayed copy for edge detect
    logic [2:0] pipe_q, pipe_d;

    always_comb begin
        pipe_d = {pipe_q[1:0], din};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_q <= {3{RST_VAL}};
        end else begin
            pipe_q <= pipe_d;
        end
    end

    assign sync = pipe_q[1];
    assign rise = pipe_q[1] & ~pipe_q[2];
    assign fall = ~pipe_q[1] & pipe_q[2];

endmodule

// File: rtl/fft_spi_in.sv
// SPI slave that assembles 2*N MSB-bit words (one per byte transfer) into a frame and
// publishes the whole frame atomically with a one-cycle valid pulse.
module fft_spi_in
    import fft_spi_in_pkg::*;
#(
    parameter int N       = FFT_N,
    parameter int MSB     = FFT_MSB,
    parameter int TIMEOUT = 1024
) (
    input  logic         clk,
    input  logic         rst_n,
    fft_spi_in_if.slave  spi
);

    localparam int WORDS = 2 * N;
    localparam int BUS_W = WORDS * MSB;
    localparam int IDX_W = $clog2(WORDS);
    localparam int BIT_W = $clog2(MSB);
    localparam int TMO_W = $clog2(TIMEOUT);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(MSB - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

    logic sclk_s, sclk_rise, sclk_fall;
    logic cs_s, cs_rise, cs_fall;
    logic mosi_s;
    logic unused_sync;

    logic [1:0]       mosi_sync_q, mosi_sync_d;
    in_state_e        state_q, state_d;
    logic [MSB-1:0]   shift_q, shift_d;
    logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [IDX_W-1:0] word_idx_q, word_idx_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic [BUS_W-1:0] shadow_q, shadow_d;
    logic [BUS_W-1:0] data_bus_q, data_bus_d;
    logic             frame_done_q, frame_done_d;
    logic             frame_valid_q, frame_valid_d;
    logic             frame_err_q, frame_err_d;
    logic [MSB-1:0]   new_word;

    spi_sync_edge #(.RST_VAL(1'b0)) u_sclk_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .din  (spi.sclk),
        .sync (sclk_s),
        .rise (sclk_rise),
        .fall (sclk_fall)
    );

    spi_sync_edge #(.RST_VAL(1'b1)) u_cs_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .din  (spi.cs),
        .sync (cs_s),
        .rise (cs_rise),
        .fall (cs_fall)
    );

    // mosi is aligned with the synchronised sclk level, so no edge stage is needed
    always_comb begin
        mosi_sync_d = {mosi_sync_q[0], spi.mosi};
    end

    assign mosi_s      = mosi_sync_q[1];
    assign new_word    = {shift_q[MSB-2:0], mosi_s};
    assign unused_sync = ^{sclk_s, sclk_fall, cs_s};

    always_comb begin
        state_d       = state_q;
        shift_d       = shift_q;
        bit_cnt_d     = bit_cnt_q;
        word_idx_d    = word_idx_q;
        tmo_d         = tmo_q;
        shadow_d      = shadow_q;
        data_bus_d    = data_bus_q;
        frame_done_d  = 1'b0;
        frame_valid_d = frame_done_q;
        frame_err_d   = 1'b0;

        if (frame_done_q) begin
            data_bus_d = shadow_q;
        end

        // Bits are taken before any cs rise in the same cycle so a final edge still completes
        if (state_q == ST_SHIFT && sclk_rise) begin
            if (bit_cnt_q == LAST_BIT) begin
                shadow_d[word_idx_q*MSB +: MSB] = new_word;
                bit_cnt_d = '0;
                if (word_idx_q == LAST_IDX) begin
                    word_idx_d   = '0;
                    frame_done_d = 1'b1;
                end else begin
                    word_idx_d = word_idx_q + 1'b1;
                end
            end else begin
                shift_d   = new_word;
                bit_cnt_d = bit_cnt_q + 1'b1;
            end
        end

        if (cs_fall) begin
            tmo_d = '0;
        end else if (state_q == ST_GAP && tmo_q != TMO_LAST) begin
            tmo_d = tmo_q + 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (cs_fall) begin
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (cs_rise) begin
                    if (bit_cnt_d != '0) begin
                        bit_cnt_d   = '0;
                        frame_err_d = 1'b1;
                    end
                    state_d = (word_idx_d == '0) ? ST_IDLE : ST_GAP;
                end
            end
            ST_GAP: begin
                if (cs_fall) begin
                    state_d = ST_SHIFT;
                end else if (tmo_q == TMO_LAST) begin
                    state_d     = ST_IDLE;
                    word_idx_d  = '0;
                    frame_err_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mosi_sync_q   <= '0;
            state_q       <= ST_IDLE;
            shift_q       <= '0;
            bit_cnt_q     <= '0;
            word_idx_q    <= '0;
            tmo_q         <= '0;
            shadow_q      <= '0;
            data_bus_q    <= '0;
            frame_done_q  <= 1'b0;
            frame_valid_q <= 1'b0;
            frame_err_q   <= 1'b0;
        end else begin
            mosi_sync_q   <= mosi_sync_d;
            state_q       <= state_d;
            shift_q       <= shift_d;
            bit_cnt_q     <= bit_cnt_d;
            word_idx_q    <= word_idx_d;
            tmo_q         <= tmo_d;
            shadow_q      <= shadow_d;
            data_bus_q    <= data_bus_d;
            frame_done_q  <= frame_done_d;
            frame_valid_q <= frame_valid_d;
            frame_err_q   <= frame_err_d;
        end
    end

    assign spi.data_bus    = data_bus_q;
    assign spi.frame_valid = frame_valid_q;
    assign spi.frame_err   = frame_err_q;
    assign spi.word_idx    = word_idx_q;

endmodule
